// File: rtl/or1200_fwd_pkg.sv
// rtl/or1200_fwd_pkg.sv - operand forwarding select encodings and defaults
package or1200_fwd_pkg;

  localparam int FWD_AW = 5;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_RF      = 2'd0;
  localparam sel_t SEL_IMM     = 2'd1;
  localparam sel_t SEL_EX_FORW = 2'd2;
  localparam sel_t SEL_WB_FORW = 2'd3;

endpackage

// File: rtl/or1200_fwd_match.sv
// rtl/or1200_fwd_match.sv - per-operand comparison of an ID source against EX/WB producers
module or1200_fwd_match
  import or1200_fwd_pkg::*;
#(
  parameter int AW = FWD_AW
) (
  input  logic [AW-1:0] src,
  input  logic          en,
  input  logic          ex_wb_en,
  input  logic [AW-1:0] ex_rd,
  input  logic          wb_wb_en,
  input  logic [AW-1:0] wb_rd,
  output logic          hit_ex,
  output logic          hit_wb,
  output sel_t          sel
);

  logic src_nz;

  // r0 is hardwired zero, so it never takes a forwarded value
  assign src_nz = |src;
  assign hit_ex = ex_wb_en & (ex_rd == src) & src_nz;
  assign hit_wb = wb_wb_en & (wb_rd == src) & src_nz;

  // EX is checked first: it holds the youngest producer
  always_comb begin
    sel = SEL_RF;
    if (en) begin
      if (hit_ex)
        sel = SEL_EX_FORW;
      else if (hit_wb)
        sel = SEL_WB_FORW;
    end
  end

endmodule

// File: rtl/or1200_fwd_sel.sv
// rtl/or1200_fwd_sel.sv - forwarding select and load-use stall; OR1200_FWD_STATS_EN adds counters
module or1200_fwd_sel
  import or1200_fwd_pkg::*;
#(
  parameter int AW    = FWD_AW,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_freeze,
  input  logic             ex_freeze,
  input  logic             wb_freeze,
  input  logic             ex_flushpipe,
  input  logic [AW-1:0]    id_rfa_addr,
  input  logic [AW-1:0]    id_rfb_addr,
  input  logic             id_rfa_en,
  input  logic             id_rfb_en,
  input  logic             id_imm_b,
  input  logic             id_rfwb,
  input  logic [AW-1:0]    id_rd_addr,
  input  logic             id_is_load,
  output sel_t             sel_a,
  output sel_t             sel_b,
  output logic             ld_stall,
  output logic [CNT_W-1:0] stat_fwd_cnt,
  output logic [CNT_W-1:0] stat_stall_cnt
);

  logic          ex_wb_en;
  logic [AW-1:0] ex_rd;
  logic          ex_load;
  logic          wb_wb_en;
  logic [AW-1:0] wb_rd;

  logic hit_ex_a, hit_wb_a, hit_ex_b, hit_wb_b;
  sel_t sel_b_rf;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wb_en <= 1'b0;
      ex_rd    <= '0;
      ex_load  <= 1'b0;
    end else if (ex_flushpipe) begin
      ex_wb_en <= 1'b0;
    end else if (ex_freeze) begin
      ex_wb_en <= ex_wb_en;
    end else if (id_freeze) begin
      ex_wb_en <= 1'b0;
      ex_load  <= 1'b0;
    end else begin
      ex_wb_en <= id_rfwb;
      ex_rd    <= id_rd_addr;
      ex_load  <= id_is_load;
    end
  end

  // A frozen EX stage hands WB a bubble so the instruction is not counted twice
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wb_en <= 1'b0;
      wb_rd    <= '0;
    end else if (!wb_freeze) begin
      wb_wb_en <= ex_wb_en & ~ex_freeze;
      wb_rd    <= ex_rd;
    end
  end

  or1200_fwd_match #(.AW(AW)) u_match_a (
    .src      (id_rfa_addr),
    .en       (id_rfa_en),
    .ex_wb_en (ex_wb_en),
    .ex_rd    (ex_rd),
    .wb_wb_en (wb_wb_en),
    .wb_rd    (wb_rd),
    .hit_ex   (hit_ex_a),
    .hit_wb   (hit_wb_a),
    .sel      (sel_a)
  );

  or1200_fwd_match #(.AW(AW)) u_match_b (
    .src      (id_rfb_addr),
    .en       (id_rfb_en),
    .ex_wb_en (ex_wb_en),
    .ex_rd    (ex_rd),
    .wb_wb_en (wb_wb_en),
    .wb_rd    (wb_rd),
    .hit_ex   (hit_ex_b),
    .hit_wb   (hit_wb_b),
    .sel      (sel_b_rf)
  );

  assign sel_b = id_imm_b ? SEL_IMM : sel_b_rf;

  // A load in EX has no result yet; the dependent op waits one cycle for WB forwarding
  assign ld_stall = ex_load & ((id_rfa_en & hit_ex_a) |
                               (id_rfb_en & ~id_imm_b & hit_ex_b));

  logic unused_hit_wb;
  assign unused_hit_wb = hit_wb_a ^ hit_wb_b;

`ifdef OR1200_FWD_STATS_EN
  logic             fwd_evt;
  logic [CNT_W-1:0] fwd_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // Both forward encodings have bit 1 set; RF and IMM do not
  assign fwd_evt = ~id_freeze & (sel_a[1] | sel_b[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (fwd_evt && (fwd_cnt != {CNT_W{1'b1}}))
        fwd_cnt <= fwd_cnt + CNT_W'(1);
      if (ld_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stat_fwd_cnt   = fwd_cnt;
  assign stat_stall_cnt = stall_cnt;
`else
  assign stat_fwd_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_or1200_fwd_sel.sv
// tb/tb_or1200_fwd_sel.sv - directed and randomized checks of or1200_fwd_sel against a pipeline model
module tb_or1200_fwd_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_freeze = 1'b0, ex_freeze = 1'b0, wb_freeze = 1'b0, ex_flushpipe = 1'b0;
  logic [4:0] id_rfa_addr = '0, id_rfb_addr = '0, id_rd_addr = '0;
  logic       id_rfa_en = 1'b0, id_rfb_en = 1'b0, id_imm_b = 1'b0, id_rfwb = 1'b0, id_is_load = 1'b0;
  logic [1:0] sel_a, sel_b;
  logic       ld_stall;
  logic [15:0] stat_fwd_cnt, stat_stall_cnt;

  int checks = 0;
  int failures = 0;

  // Pipeline model: one record per stage holding the producing instruction
  typedef struct {
    bit       writes;
    bit [4:0] rd;
    bit       load;
  } slot_t;

  slot_t m_ex = '{0, 0, 0};
  slot_t m_wb = '{0, 0, 0};
  int    m_fwd = 0;
  int    m_stall = 0;

  or1200_fwd_sel dut (
    .clk(clk), .rst(rst),
    .id_freeze(id_freeze), .ex_freeze(ex_freeze), .wb_freeze(wb_freeze),
    .ex_flushpipe(ex_flushpipe),
    .id_rfa_addr(id_rfa_addr), .id_rfb_addr(id_rfb_addr),
    .id_rfa_en(id_rfa_en), .id_rfb_en(id_rfb_en), .id_imm_b(id_imm_b),
    .id_rfwb(id_rfwb), .id_rd_addr(id_rd_addr), .id_is_load(id_is_load),
    .sel_a(sel_a), .sel_b(sel_b), .ld_stall(ld_stall),
    .stat_fwd_cnt(stat_fwd_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit produces(slot_t s, bit [4:0] src);
    return s.writes && (s.rd == src) && (src != 0);
  endfunction

  function automatic int src_sel(bit en, bit [4:0] src);
    if (!en) return 0;
    if (produces(m_ex, src)) return 2;
    if (produces(m_wb, src)) return 3;
    return 0;
  endfunction

  function automatic int exp_a();
    return src_sel(id_rfa_en, id_rfa_addr);
  endfunction

  function automatic int exp_b();
    return id_imm_b ? 1 : src_sel(id_rfb_en, id_rfb_addr);
  endfunction

  function automatic int exp_ld();
    return (m_ex.load && ((id_rfa_en && produces(m_ex, id_rfa_addr)) ||
            (id_rfb_en && !id_imm_b && produces(m_ex, id_rfb_addr)))) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input bit [4:0] a, input bit aen, input bit [4:0] b, input bit ben,
                        input bit imm, input bit wb, input bit [4:0] rd, input bit ld);
    id_rfa_addr = a; id_rfa_en = aen; id_rfb_addr = b; id_rfb_en = ben;
    id_imm_b = imm; id_rfwb = wb; id_rd_addr = rd; id_is_load = ld;
  endtask

  // Check outputs against the model (and optional directed constants), then advance one clock
  task automatic cyc(input string tag, input int ea = -1, input int eb = -1, input int el = -1);
    int ma, mb, ml;
    #1;
    ma = exp_a(); mb = exp_b(); ml = exp_ld();
    chk({tag, ".sel_a"}, sel_a, ma);
    chk({tag, ".sel_b"}, sel_b, mb);
    chk({tag, ".ld_stall"}, ld_stall, ml);
`ifdef OR1200_FWD_STATS_EN
    chk({tag, ".fwd_cnt"}, stat_fwd_cnt, m_fwd);
    chk({tag, ".stall_cnt"}, stat_stall_cnt, m_stall);
`else
    chk({tag, ".fwd_cnt"}, stat_fwd_cnt, 0);
    chk({tag, ".stall_cnt"}, stat_stall_cnt, 0);
`endif
    if (ea >= 0) chk({tag, ".dir_a"}, sel_a, ea);
    if (eb >= 0) chk({tag, ".dir_b"}, sel_b, eb);
    if (el >= 0) chk({tag, ".dir_ld"}, ld_stall, el);
    @(posedge clk);
    if (rst) begin
      m_ex = '{0, 0, 0}; m_wb = '{0, 0, 0}; m_fwd = 0; m_stall = 0;
    end else begin
      if (!id_freeze && (ma >= 2 || mb >= 2) && m_fwd < 65535) m_fwd++;
      if (ml == 1 && m_stall < 65535) m_stall++;
      if (!wb_freeze) begin
        m_wb.writes = m_ex.writes && !ex_freeze;
        m_wb.rd     = m_ex.rd;
      end
      if (ex_flushpipe) m_ex.writes = 0;
      else if (ex_freeze) ;
      else if (id_freeze) begin m_ex.writes = 0; m_ex.load = 0; end
      else m_ex = '{id_rfwb, id_rd_addr, id_is_load};
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc("reset", 0, 0, 0);
    rst = 1'b0;

    set_id(0, 0, 0, 0, 0, 1, 3, 0); cyc("b2b_i1");
    set_id(3, 1, 0, 0, 0, 0, 0, 0); cyc("b2b_i2", 2, 0, 0);
    set_id(3, 1, 0, 0, 0, 0, 0, 0); cyc("b2b_i3", 3, 0, 0);

    set_id(0, 0, 0, 0, 0, 1, 5, 1); cyc("lu_load", 0, 0, 0);
    set_id(0, 0, 5, 1, 0, 0, 0, 0); id_freeze = 1'b1; cyc("lu_stall", 0, 2, 1);
    id_freeze = 1'b0;               cyc("lu_resume", 0, 3, 0);

    set_id(0, 0, 0, 0, 0, 1, 7, 1); cyc("imm_load", 0, 0, 0);
    set_id(0, 0, 7, 1, 1, 0, 0, 0); cyc("imm_prio", 0, 1, 0);

    set_id(0, 0, 0, 0, 0, 1, 0, 0); cyc("r0_write");
    set_id(0, 1, 0, 0, 0, 0, 0, 0); cyc("r0_read", 0, 0, 0);
    set_id(0, 0, 0, 0, 0, 1, 4, 0); cyc("dis_write");
    set_id(4, 0, 0, 0, 0, 0, 0, 0); cyc("dis_read", 0, 0, 0);

    set_id(0, 0, 0, 0, 0, 1, 2, 0); cyc("same_rd1");
    cyc("same_rd2");
    set_id(2, 1, 0, 0, 0, 0, 0, 0); cyc("same_rd_ex_wins", 2, 0, 0);

    set_id(0, 0, 0, 0, 0, 1, 9, 0); cyc("frz_write");
    set_id(9, 1, 0, 0, 0, 0, 0, 0); ex_freeze = 1'b1; id_freeze = 1'b1;
    repeat (3) cyc("frz_hold", 2, 0, 0);
    ex_flushpipe = 1'b1;            cyc("flush_frozen", 2, 0, 0);
    ex_flushpipe = 1'b0; ex_freeze = 1'b0;
    cyc("flush_after", 0, 0, 0);
    id_freeze = 1'b0;

    set_id(0, 0, 0, 0, 0, 1, 5, 1); cyc("rs_load");
    set_id(0, 0, 5, 1, 0, 0, 0, 0); id_freeze = 1'b1; rst = 1'b1;
    cyc("rs_stall", 0, 2, 1);
    rst = 1'b0;                     cyc("rs_after", 0, 0, 0);
    id_freeze = 1'b0;

    for (int i = 0; i < 400; i++) begin
      set_id(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
      ex_freeze    = ($urandom_range(0, 7) == 0);
      wb_freeze    = ($urandom_range(0, 7) == 0);
      ex_flushpipe = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 63) == 0);
      #0;
      id_freeze    = (exp_ld() == 1) || ($urandom_range(0, 9) == 0);
      cyc("rand");
    end
    ex_freeze = 1'b0; wb_freeze = 1'b0; ex_flushpipe = 1'b0; id_freeze = 1'b0;

`ifdef OR1200_FWD_STATS_EN
    rst = 1'b1; set_id(0, 0, 0, 0, 0, 0, 0, 0); cyc("st_rst");
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 1, 3, 0); cyc("st_w");
    repeat (5) begin
      set_id(3, 1, 0, 0, 0, 1, 3, 0); cyc("st_fwd", 2, 0, 0);
    end
    set_id(0, 0, 0, 0, 0, 1, 6, 1); cyc("st_load");
    set_id(0, 0, 6, 1, 0, 0, 0, 0); id_freeze = 1'b1; cyc("st_stall", 0, 2, 1);
    chk("stat_fwd_5", stat_fwd_cnt, 5);
    chk("stat_stall_1", stat_stall_cnt, 1);
    id_freeze = 1'b0;

    rst = 1'b1; set_id(0, 0, 0, 0, 0, 0, 0, 0); cyc("sat_rst");
    rst = 1'b0;
    set_id(3, 1, 0, 0, 0, 1, 3, 0);
    repeat (65540) cyc("sat");
    chk("stat_fwd_sat", stat_fwd_cnt, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
